// File: rtl/pwm_duty_ramp_sequencer.sv
// rtl/pwm_duty_ramp_sequencer.sv - duty ramp sequencer feeding pwm_controller.duty
module pwm_duty_ramp_sequencer #(
    parameter int unsigned STEP_CYCLES = 80_000,
    parameter int unsigned DUTY_W      = 4,
    parameter int unsigned DUTY_RST    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DUTY_W-1:0] cmd_target,
    input  logic [3:0]        cmd_rate,
    input  logic              abort,
    output logic [DUTY_W-1:0] duty,
    output logic              busy,
    output logic              done
);

    localparam int unsigned       TW        = $clog2(STEP_CYCLES);
    localparam logic [TW-1:0]     STEP_LAST = TW'(STEP_CYCLES - 1);
    localparam logic [DUTY_W-1:0] DUTY_INIT = DUTY_W'(DUTY_RST);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RAMP,
        ST_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] target_q, target_d;
    logic [3:0]        rate_q, rate_d;
    logic              up_q, up_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [3:0]        intv_q, intv_d;

    logic              step_wrap;
    logic              step_now;
    logic [DUTY_W-1:0] duty_step;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            duty_q   <= DUTY_INIT;
            target_q <= DUTY_INIT;
            rate_q   <= '0;
            up_q     <= 1'b0;
            timer_q  <= '0;
            intv_q   <= '0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            rate_q   <= rate_d;
            up_q     <= up_d;
            timer_q  <= timer_d;
            intv_q   <= intv_d;
        end
    end

    // A step fires on the timer wrap that closes the last interval of the rate.
    assign step_wrap = (timer_q == STEP_LAST);
    assign step_now  = step_wrap && (intv_q == (rate_q - 4'd1));
    assign duty_step = up_q ? (duty_q + DUTY_W'(1)) : (duty_q - DUTY_W'(1));

    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        rate_d   = rate_q;
        up_d     = up_q;
        timer_d  = timer_q;
        intv_d   = intv_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    target_d = cmd_target;
                    rate_d   = cmd_rate;
                    up_d     = (cmd_target > duty_q);
                    timer_d  = '0;
                    intv_d   = '0;
                    if (cmd_target == duty_q) begin
                        state_d = ST_DONE;
                    end else if (cmd_rate == 4'd0) begin
                        duty_d  = cmd_target;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RAMP;
                    end
                end
            end

            ST_RAMP: begin
                if (step_wrap) begin
                    timer_d = '0;
                    if (step_now) begin
                        intv_d = '0;
                        duty_d = duty_step;
                        if (duty_step == target_q) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        intv_d = intv_q + 4'd1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
                // A step landing on the abort edge is still taken; only the done pulse is lost.
                if (abort) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                    intv_d  = '0;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign duty      = duty_q;
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

endmodule
